// File: rtl/result_bcd.sv
// Converts a signed calculator result into six BCD digits with sign, status code
// and leading-zero blank mask, using a bit-serial double-dabble over 20 cycles.
module result_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [1:0]  code,
    output logic        neg,
    output logic [23:0] digits,
    output logic [5:0]  blank
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]        ERR_WORD  = 32'h00EE_0000;
    localparam logic [31:0]        INIT_WORD = 32'h00CC_0000;
    localparam logic signed [31:0] MAX_EXCL  = 32'sd1000000;
    localparam logic signed [31:0] MIN_INCL  = -32'sd100000;
    localparam logic [1:0]         CODE_NUM  = 2'd0;
    localparam logic [1:0]         CODE_ERR  = 2'd1;
    localparam logic [1:0]         CODE_INIT = 2'd2;
    localparam logic [4:0]         LAST_ITER = 5'd19;

    state_t       state_r;
    state_t       state_s;
    logic [4:0]   count_r;
    logic [43:0]  shift_r;
    logic [1:0]   pend_code_r;
    logic         pend_neg_r;
    logic [1:0]   class_code_s;
    logic [19:0]  mag_s;
    logic         neg_s;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [43:0] dd_step(input logic [43:0] s);
        logic [23:0] b;
        b = s[43:20];
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                b[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                b[4*i +: 4] = b[4*i +: 4];
            end
        end
        return {b[22:0], s[19:0], 1'b0};
    endfunction

    // Leading-zero mask; the least significant digit is never blanked.
    function automatic logic [5:0] blank_mask(input logic [23:0] d);
        logic       run;
        logic [5:0] m;
        run = 1'b1;
        m   = 6'b000000;
        for (int i = 5; i >= 1; i--) begin
            run  = run & (d[4*i +: 4] == 4'd0);
            m[i] = run;
        end
        return m;
    endfunction

    // Classify the incoming word and form its 20-bit magnitude.
    always_comb begin
        neg_s = result[31];
        mag_s = result[31] ? (20'd0 - result[19:0]) : result[19:0];
        if (result == ERR_WORD) begin
            class_code_s = CODE_ERR;
        end else if (result == INIT_WORD) begin
            class_code_s = CODE_INIT;
        end else if (($signed(result) >= MAX_EXCL) || ($signed(result) <= MIN_INCL)) begin
            class_code_s = CODE_ERR;
        end else begin
            class_code_s = CODE_NUM;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_s = (class_code_s == CODE_NUM) ? CONV : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (count_r == LAST_ITER) begin
                    state_s = DONE;
                end else begin
                    state_s = CONV;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 5'd0;
            shift_r     <= 44'd0;
            pend_code_r <= CODE_INIT;
            pend_neg_r  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            valid       <= 1'b0;
            code        <= CODE_INIT;
            neg         <= 1'b0;
            digits      <= 24'd0;
            blank       <= 6'b111111;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        busy        <= 1'b1;
                        pend_code_r <= class_code_s;
                        pend_neg_r  <= (class_code_s == CODE_NUM) && neg_s;
                        shift_r     <= {24'd0, mag_s};
                        count_r     <= 5'd0;
                    end
                end
                CONV: begin
                    shift_r <= dd_step(shift_r);
                    count_r <= count_r + 5'd1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    valid <= 1'b1;
                    code  <= pend_code_r;
                    if (pend_code_r == CODE_NUM) begin
                        digits <= shift_r[43:20];
                        neg    <= pend_neg_r;
                        blank  <= blank_mask(shift_r[43:20]);
                    end else begin
                        digits <= 24'd0;
                        neg    <= 1'b0;
                        blank  <= 6'b111111;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/result_bcd.md
RESULT_BCD -- requirements
Module: result_bcd

Interface
REQ-001 The block SHALL provide these ports (clock and reset first):
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- result  input  32  calculator output: signed two's-complement value, or code word 0x00EE0000 (error) / 0x00CC0000 (init).
- load  input  1  request to convert the current result; sampled on rising edge.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when outputs are updated.
- valid  output  1  level; digits/code hold a completed conversion.
- code  output  2  0 = numeric, 1 = error (EE), 2 = init/blank (CC); 3 unused.
- neg  output  1  numeric value is negative.
- digits  output  24  six BCD digits; [23:20] is the most significant, [3:0] the least significant.
- blank  output  6  per-digit leading-zero blank mask; bit 5 is the MS digit.
REQ-002 The block SHALL have one clock domain and one synchronous active-high reset; it SHALL have no parameters.

Function
REQ-003 FSM states: IDLE, CONV, DONE. Reset state: IDLE.
REQ-004 In IDLE with load=1 at edge k, the block SHALL capture result and set busy=1 from edge k.
REQ-005 Classification at capture (priority order):
- 0x00EE0000 -> error.
- 0x00CC0000 -> init.
- value >= 1_000_000 or value <= -100_000 -> error.
- otherwise -> numeric.
REQ-006 Error/init path: state goes to DONE at edge k; outputs update at edge k+1 with code=1 or 2, digits=0, neg=0, blank=111111.
REQ-007 Numeric path: magnitude = |value| as 20 bits; neg = value<0.
- CONV runs double-dabble, one bit per cycle: add-3 to any BCD nibble >= 5, then shift left by 1.
- 20 iterations run on edges k+1..k+20, counted by a 5-bit counter.
REQ-008 Numeric outputs SHALL update at edge k+21: digits = BCD of magnitude, code=0, neg per REQ-007.
REQ-009 On every output update: done=1 for exactly one cycle, valid=1, busy=0; state returns to IDLE on the same edge.
REQ-010 blank: bit i=1 when digit i and all more-significant digits are zero; bit 0 SHALL always be 0 for numeric results.
REQ-011 load while busy=1 SHALL be ignored; it is neither queued nor counted.
REQ-012 load in the same cycle done=1 SHALL be accepted (state is IDLE in that cycle); busy rises at that edge.
REQ-013 digits, code, neg, blank and valid SHALL hold their values between updates; a new conversion SHALL NOT disturb them until its own completion edge.
REQ-014 result changes after capture SHALL have no effect on the conversion in progress.
REQ-015 A negative value of zero magnitude cannot occur; -0 is not representable, so neg=0 whenever magnitude=0.

Reset
REQ-016 With rst=1 at an edge, the block SHALL set:
- state=IDLE, busy=0, done=0, valid=0;
- code=2, neg=0, digits=0, blank=111111;
- counter and internal shift register to 0.
REQ-017 rst SHALL take priority over load.
REQ-018 rst asserted mid-conversion SHALL abort the conversion; no done pulse is produced for the aborted request.

Verification
REQ-019 The bench SHALL cover at least these directed scenarios:
- load, result=0 -> at k+21: digits=000000, neg=0, code=0, blank=111110, one-cycle done.
- load, result=999999 -> digits=999999, blank=000000, code=0; busy high for exactly 21 cycles.
- load, result=-99999 (0xFFFE7961) -> neg=1, digits=099999, blank=100000.
- load, result=0x00EE0000 -> at k+1: code=1, blank=111111.
- load, result=1000000 -> code=1.
- load, result=-100000 -> code=1.
- load, result=0x00CC0000 -> code=2.
- load 4321, pulse load again at k+5 (ignored), then rst=1 at k+10 -> busy=0, valid=0, code=2 after that edge, no done.
- Reload 4321 -> digits=004321, blank=110000.
- Back-to-back: second load in the done cycle -> second result completes 21 cycles later; first outputs are held until then.
